// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-style SRAM responder with programmable wait states and two-cycle ERROR response
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif
module ahb_sram_slave #(
  parameter int ADDR_WIDTH = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int WAIT_STATES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       HSel,
  input  logic [31:0]                HAddress,
  input  logic [31:0]                HWrite_data,
  input  logic [`AHB_TRANS_BITS-1:0] HTrans,
  input  logic [`AHB_SIZE_BITS-1:0]  HSize,
  input  logic                       HWrite,
  output logic                       HReady,
  output logic [1:0]                 HResp,
  output logic [31:0]                HRead_data
);
  typedef enum logic [2:0] {IDLE, WAIT, RESP, ERR1, ERR2} state_t;
  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  state_t state, nxt, issue;
  logic [3:0] cnt;
  logic wr_q;
  logic [31:0] rdata_q;
  logic [31:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic acc, legal, in_win;
  logic [3:0] be;
  logic [ADDR_WIDTH-1:0] idx;
  // BASE_ADDR is window-aligned, so the window test is a compare of the upper address bits
  assign in_win = HAddress[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2];
  assign idx = HAddress[ADDR_WIDTH+1:2];
  assign acc = HSel && HReady && (HTrans inside {2'b10, 2'b11});
  assign legal = in_win && HSize <= 3'd2 && !(HSize == 3'd1 && HAddress[0]) &&
                 !(HSize == 3'd2 && HAddress[1:0] != 2'b00);
  assign be = HSize == 3'd0 ? 4'b0001 << HAddress[1:0] :
              HSize == 3'd1 ? (HAddress[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign HReady = state != WAIT && state != ERR1;
  assign HResp = {1'b0, state == ERR1 || state == ERR2};
  assign HRead_data = state == RESP && !wr_q ? rdata_q : '0;
  always_comb begin
    nxt = state;
    issue = !legal ? ERR1 : (WAIT_STATES > 0 ? WAIT : RESP);
    unique case (state)
      WAIT:    nxt = cnt == 4'd0 ? RESP : WAIT;
      ERR1:    nxt = ERR2;
      default: nxt = acc ? issue : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      wr_q <= 1'b0;
    end else begin
      state <= nxt;
      if (acc) wr_q <= HWrite;
      cnt <= acc ? WS_LOAD : (state == WAIT && cnt != 4'd0 ? cnt - 4'd1 : cnt);
    end
  end
  // SRAM array and read capture are not reset; HRead_data is gated by state instead
  always_ff @(posedge clk) begin
    if (acc && legal && HWrite)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= HWrite_data[8*i +: 8];
    if (acc && legal && !HWrite) rdata_q <= mem[idx];
  end
endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: directed vector table plus hand sequences for the AHB SRAM slave
`timescale 1ns/1ps
module tb_ahb_sram_slave;
  localparam logic [31:0] B = 32'h0001_0000;
  typedef struct {
    int d;
    logic [31:0] a;
    logic w;
    logic [2:0] s;
    logic [31:0] wd;
    int lows;
    logic [1:0] rsp;
    logic [31:0] rd;
  } vec_t;
  logic clk = 0;
  logic rst = 0;
  logic [3:0] sel = 0;
  logic [31:0] addr = 0, wdata = 0;
  logic [1:0] trans = 0;
  logic [2:0] size = 0;
  logic wr = 0;
  logic [3:0] rdy;
  logic [1:0] rsp [4];
  logic [31:0] rdt [4];
  int cyc = 0;
  int errors = 0, checks = 0;
  vec_t v [$];
  int lows, acc_cyc, prev;
  logic [1:0] rsp_lo, rsp_hi;
  logic [31:0] rd;
  logic rd_bad;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ahb_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(B), .WAIT_STATES(1)) u0 (
    .clk(clk), .rst(rst), .HSel(sel[0]), .HAddress(addr), .HWrite_data(wdata), .HTrans(trans),
    .HSize(size), .HWrite(wr), .HReady(rdy[0]), .HResp(rsp[0]), .HRead_data(rdt[0]));
  ahb_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(B), .WAIT_STATES(0)) u1 (
    .clk(clk), .rst(rst), .HSel(sel[1]), .HAddress(addr), .HWrite_data(wdata), .HTrans(trans),
    .HSize(size), .HWrite(wr), .HReady(rdy[1]), .HResp(rsp[1]), .HRead_data(rdt[1]));
  ahb_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(B), .WAIT_STATES(3)) u2 (
    .clk(clk), .rst(rst), .HSel(sel[2]), .HAddress(addr), .HWrite_data(wdata), .HTrans(trans),
    .HSize(size), .HWrite(wr), .HReady(rdy[2]), .HResp(rsp[2]), .HRead_data(rdt[2]));
  ahb_sram_slave #(.ADDR_WIDTH(10), .BASE_ADDR(B), .WAIT_STATES(15)) u3 (
    .clk(clk), .rst(rst), .HSel(sel[3]), .HAddress(addr), .HWrite_data(wdata), .HTrans(trans),
    .HSize(size), .HWrite(wr), .HReady(rdy[3]), .HResp(rsp[3]), .HRead_data(rdt[3]));

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  function automatic vec_t mk(int d, logic [31:0] a, logic w, logic [2:0] s, logic [31:0] wd,
                              int lw, logic [1:0] r, logic [31:0] rdv);
    vec_t x;
    x.d = d; x.a = a; x.w = w; x.s = s; x.wd = wd; x.lows = lw; x.rsp = r; x.rd = rdv;
    return x;
  endfunction

  // one transfer on DUT d; counts HReady-low cycles after the accept edge
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [2:0] s,
                      input logic [31:0] wd, output int nl, output logic [1:0] r_lo,
                      output logic [1:0] r_hi, output logic [31:0] rdo, output logic bad,
                      output int ac);
    @(negedge clk);
    sel = 4'b0001 << d; addr = a; wr = w; size = s; wdata = wd; trans = 2'b10;
    @(posedge clk); #1;
    ac = cyc;
    sel = 0; trans = 0; wr = 0;
    nl = 0; r_lo = 0; bad = 0;
    while (!rdy[d] && nl < 40) begin
      r_lo = rsp[d];
      if (rdt[d] != 0) bad = 1;
      @(posedge clk); #1;
      nl++;
    end
    r_hi = rsp[d]; rdo = rdt[d];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    v.push_back(mk(0, B + 32'h10,  1, 2, 32'hDEADBEEF, 1, 2'b00, 32'h0));
    v.push_back(mk(0, B + 32'h10,  0, 2, 32'h0,        1, 2'b00, 32'hDEADBEEF));
    v.push_back(mk(0, B + 32'h0,   1, 2, 32'h0,        1, 2'b00, 32'h0));
    v.push_back(mk(0, B + 32'h1,   1, 0, 32'h0000AA00, 1, 2'b00, 32'h0));
    v.push_back(mk(0, B + 32'h2,   1, 1, 32'h55660000, 1, 2'b00, 32'h0));
    v.push_back(mk(0, B + 32'h0,   0, 2, 32'h0,        1, 2'b00, 32'h5566AA00));
    v.push_back(mk(0, B + 32'h1000,0, 2, 32'h0,        1, 2'b01, 32'h0));
    v.push_back(mk(0, B + 32'h2,   1, 2, 32'hFFFFFFFF, 1, 2'b01, 32'h0));
    v.push_back(mk(0, B + 32'h10,  1, 3, 32'h0,        1, 2'b01, 32'h0));
    v.push_back(mk(0, B + 32'h1,   1, 1, 32'hFFFFFFFF, 1, 2'b01, 32'h0));
    v.push_back(mk(0, B - 32'h4,   0, 2, 32'h0,        1, 2'b01, 32'h0));
    v.push_back(mk(0, B + 32'h0,   0, 2, 32'h0,        1, 2'b00, 32'h5566AA00));
    v.push_back(mk(0, B + 32'h10,  0, 0, 32'h0,        1, 2'b00, 32'hDEADBEEF));
    v.push_back(mk(0, B + 32'hFFC, 1, 2, 32'h12345678, 1, 2'b00, 32'h0));
    v.push_back(mk(0, B + 32'hFFC, 0, 2, 32'h0,        1, 2'b00, 32'h12345678));
    v.push_back(mk(1, B + 32'h20,  1, 2, 32'hCAFEF00D, 0, 2'b00, 32'h0));
    v.push_back(mk(1, B + 32'h20,  0, 2, 32'h0,        0, 2'b00, 32'hCAFEF00D));
    v.push_back(mk(2, B + 32'h20,  1, 2, 32'hCAFEF00D, 3, 2'b00, 32'h0));
    v.push_back(mk(2, B + 32'h20,  0, 2, 32'h0,        3, 2'b00, 32'hCAFEF00D));
    v.push_back(mk(3, B + 32'h20,  1, 2, 32'hCAFEF00D, 15, 2'b00, 32'h0));
    v.push_back(mk(3, B + 32'h20,  0, 2, 32'h0,        15, 2'b00, 32'hCAFEF00D));
    v.push_back(mk(3, B + 32'h20,  0, 3, 32'h0,        1, 2'b01, 32'h0));
    v.push_back(mk(3, B + 32'h20,  0, 2, 32'h0,        15, 2'b00, 32'hCAFEF00D));
    repeat (2) @(posedge clk);
    #1;
    chk("reset HReady", {28'h0, rdy}, 32'hF);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset HResp u%0d", k), {30'h0, rsp[k]}, 32'h0);
      chk($sformatf("reset HRead_data u%0d", k), rdt[k], 32'h0);
    end
    @(negedge clk);
    rst = 1;
    foreach (v[i]) begin
      xfer(v[i].d, v[i].a, v[i].w, v[i].s, v[i].wd, lows, rsp_lo, rsp_hi, rd, rd_bad, acc_cyc);
      chk($sformatf("v%0d low_cycles", i), lows, v[i].lows);
      if (v[i].lows > 0) chk($sformatf("v%0d resp_wait", i), {30'h0, rsp_lo}, {30'h0, v[i].rsp});
      chk($sformatf("v%0d resp_done", i), {30'h0, rsp_hi}, {30'h0, v[i].rsp});
      chk($sformatf("v%0d rdata", i), rd, v[i].rd);
      chk($sformatf("v%0d rdata_wait_zero", i), {31'h0, rd_bad}, 32'h0);
    end
    @(negedge clk);
    sel = 0; trans = 2'b10; wr = 1; addr = B + 32'h10; wdata = 32'h0; size = 2;
    repeat (3) begin
      @(posedge clk); #1;
      chk("desel HReady", {28'h0, rdy}, 32'hF);
      chk("desel HResp", {30'h0, rsp[0] | rsp[1] | rsp[2] | rsp[3]}, 32'h0);
    end
    trans = 0; wr = 0;
    xfer(0, B + 32'h10, 0, 2, 0, lows, rsp_lo, rsp_hi, rd, rd_bad, acc_cyc);
    chk("desel readback", rd, 32'hDEADBEEF);
    prev = 0;
    for (int i = 0; i < 8; i++) begin
      xfer(1, B + 32'h30 + 32'(4 * (i % 4)), i < 4, 2, 32'h1111_1111 * (i % 4 + 1),
           lows, rsp_lo, rsp_hi, rd, rd_bad, acc_cyc);
      chk($sformatf("b2b%0d low_cycles", i), lows, 0);
      if (i > 0) chk($sformatf("b2b%0d gap", i), acc_cyc - prev, 1);
      chk($sformatf("b2b%0d rdata", i), rd, i < 4 ? 32'h0 : 32'h1111_1111 * (i % 4 + 1));
      prev = acc_cyc;
    end
    @(negedge clk);
    sel = 4'b0010; addr = B + 32'h34; wr = 0; size = 2; trans = 2'b10;
    @(posedge clk); #1;
    sel = 0; trans = 0;
    chk("rst_resp pre rdata", rdt[1], 32'h2222_2222);
    rst = 0;
    #1;
    chk("rst_resp rdata", rdt[1], 32'h0);
    chk("rst_resp HReady", {31'h0, rdy[1]}, 32'h1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    sel = 4'b0100; addr = B + 32'h40; wr = 1; size = 2; wdata = 32'h0BADF00D; trans = 2'b10;
    @(posedge clk); #1;
    sel = 0; trans = 0; wr = 0;
    chk("rst_wait pre HReady", {31'h0, rdy[2]}, 32'h0);
    #2;
    rst = 0;
    #1;
    chk("rst_wait HReady", {31'h0, rdy[2]}, 32'h1);
    chk("rst_wait HResp", {30'h0, rsp[2]}, 32'h0);
    chk("rst_wait rdata", rdt[2], 32'h0);
    @(negedge clk);
    rst = 1;
    xfer(2, B + 32'h40, 0, 2, 0, lows, rsp_lo, rsp_hi, rd, rd_bad, acc_cyc);
    chk("rst_wait readback low_cycles", lows, 3);
    chk("rst_wait readback", rd, 32'h0BADF00D);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ahb_sram_slave.md
# ahb_sram_slave

Bus-side responder for the AHB-style transfers issued by the cache/CPU bus master. It decodes one address window and serves single word, half-word and byte transfers from an internal word-addressed SRAM. It inserts a programmable number of wait states and returns OKAY or a two-cycle ERROR response. It sits on the slave side of the bus, behind the decoder that drives HSel.

## Interface
Parameters:
- ADDR_WIDTH, 10, word-address bits; the SRAM holds 2^ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h0000_0000, byte base of the decoded window; must be aligned to the window size.
- WAIT_STATES, 1, number of HReady-low cycles before a read/write completes; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- HSel  in  1  slave select from the bus decoder.
- HAddress  in  32  byte address; valid in the address phase.
- HWrite_data  in  32  write data; presented by the master in the address phase, together with HAddress.
- HTrans  in  `AHB_TRANS_BITS  transfer type; bit 1 set (NONSEQ/SEQ) means active.
- HSize  in  `AHB_SIZE_BITS  transfer size: 0 = byte, 1 = half-word, 2 = word; any other value is illegal.
- HWrite  in  1  1 = write, 0 = read.
- HReady  out  1  high = the slave accepts an address phase and the current data phase is complete.
- HResp  out  2  response: 2'b00 = OKAY, 2'b01 = ERROR.
- HRead_data  out  32  read data; valid only in the completing cycle of a read.

## Operation
- Accept condition: HSel && HTrans[1] && HReady, sampled at posedge. At that edge the block latches HAddress, HWrite, HSize and HWrite_data.
- Legality check, performed at accept:
  - Address must lie in [BASE_ADDR, BASE_ADDR + 4*2^ADDR_WIDTH).
  - HSize must be ≤ 2.
  - Half-word transfers require HAddress[0] = 0.
  - Word transfers require HAddress[1:0] = 0.
  - Any failure selects the error path. No SRAM access is made.
- Writes:
  - The write is committed to SRAM at the accept edge.
  - Byte lanes: byte writes only lane HAddress[1:0]. Half-word writes lanes {2'b11, 2'b10} when HAddress[1] = 1, else {2'b01, 2'b00}. Word writes all four lanes.
  - Lane n takes HWrite_data[8n+7:8n] (same lane, no shifting).
- Reads:
  - Always return the full addressed word regardless of HSize.
  - Word index = (HAddress - BASE_ADDR) >> 2.
- FSM states:
  - IDLE: HReady = 1, HResp = OKAY. On a legal accept: go to WAIT if WAIT_STATES > 0, else RESP. On an illegal accept: go to ERR1.
  - WAIT: HReady = 0. A down-counter loads WAIT_STATES - 1 at accept. Go to RESP when the counter reaches 0, else decrement.
  - RESP: HReady = 1, HResp = OKAY. HRead_data = the latched read word for a read, 0 for a write. A new accept in this cycle is legal (back-to-back) and follows the IDLE rules; otherwise go to IDLE.
  - ERR1: HReady = 0, HResp = ERROR. Always go to ERR2.
  - ERR2: HReady = 1, HResp = ERROR. A new accept is allowed, following the IDLE rules; otherwise go to IDLE.
- Non-accept inputs: HSel = 0 or an IDLE/BUSY HTrans in IDLE, RESP or ERR2 produces no transfer and returns an OKAY, zero-wait idle response.
- In WAIT and ERR1 the address inputs are ignored, because HReady is low.
- Read-after-write: a read accepted in the RESP cycle of a write to the same word returns the new data.

## Timing
- Reset values, asynchronous on rst low: state = IDLE, HReady = 1, HResp = 2'b00, HRead_data = 0, wait counter = 0. SRAM contents are not reset.
- Reset asserted mid-transfer: the transfer is aborted and the outputs take their reset values immediately. A write already accepted stays committed.
- Latency, counted from the accept edge: WAIT_STATES cycles with HReady = 0, then 1 completing cycle with HReady = 1. Total data phase = WAIT_STATES + 1 cycles.
- Error: exactly 2 cycles regardless of WAIT_STATES. The first cycle has HReady = 0, HResp = ERROR. The second has HReady = 1, HResp = ERROR.
- HRead_data is 0 in every cycle except the completing cycle of a read.
- Sustained throughput with WAIT_STATES = 0: one transfer per cycle.

## Test plan
- Word write then read: write 32'hDEADBEEF to BASE_ADDR + 0x10, then read it back, WAIT_STATES = 1. Required: each transfer has 1 HReady-low cycle, then HReady = 1 with HResp = OKAY. The read completes with HRead_data = 32'hDEADBEEF.
- Byte and half-word lanes: word 0 = 32'h0; write byte 8'hAA to address +1; write half-word 16'h5566 (placed on HWrite_data[31:16]) to address +2. Required: a word read returns 32'h5566AA00.
- Wait-state sweep: repeat the same read with WAIT_STATES = 0, 3 and 15. Required: exactly 0, 3 and 15 HReady-low cycles respectively, data correct each time.
- Errors, checked separately: a read at BASE_ADDR + 4*2^ADDR_WIDTH, a word write at offset 0x2, and HSize = 3. Required for each: one cycle HReady = 0 / HResp = 2'b01, then one cycle HReady = 1 / HResp = 2'b01. Memory must be unchanged, confirmed by readback.
- Back-to-back and reset: with WAIT_STATES = 0, four consecutive writes followed by four reads. Required: no idle cycles between transfers and correct data on every read. Then assert rst during a WAIT cycle. Required: HReady = 1, HResp = 0 and HRead_data = 0 immediately, with no clock edge.
- Deselected: HSel = 0 with HTrans = NONSEQ and a write. Required: no SRAM change, HReady stays 1 and HResp stays OKAY.
